// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory port between an instruction-fetch
// port (I, read only) and a data port (D, read/write). A four-state FSM
// (IDLE -> ISSUE -> WAIT -> DONE) runs one access at a time. Ties alternate
// between the ports, and a stuck memory is cut off after TIMEOUT wait cycles.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IREAD,
    input  logic [ADDR_W-1:0] IADDR,
    output logic              I_BUSYWAIT,
    output logic [DATA_W-1:0] I_RDATA,
    input  logic              DREAD,
    input  logic              DWRITE,
    input  logic [ADDR_W-1:0] DADDR,
    input  logic [DATA_W-1:0] DWDATA,
    output logic              D_BUSYWAIT,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // grant_q doubles as the last-grant register used for tie-breaking.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    state_e              state_q, state_d;
    grant_e              grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                err_q, err_d;

    logic i_req;
    logic d_req;

    assign i_req = IREAD;
    assign d_req = DREAD | DWRITE;

    // Next-state logic: arbitration in IDLE, completion/timeout handling in WAIT.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case statement leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_d = S_ISSUE;
                    // I wins when alone, or on a tie when D was served last.
                    if (i_req && (!d_req || grant_q == GNT_D)) begin
                        grant_d     = GNT_I;
                        mem_addr_d  = IADDR;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end else begin
                        grant_d     = GNT_D;
                        mem_addr_d  = DADDR;
                        mem_wdata_d = DWDATA;
                        // Read and write together is treated as a write.
                        mem_write_d = DWRITE;
                        mem_read_d  = ~DWRITE;
                    end
                end
            end

            S_ISSUE: begin
                // MEM_BUSYWAIT is not looked at here; the memory gets one cycle
                // to see the strobe before we trust its busy flag.
                state_d = S_WAIT;
                cnt_d   = '0;
            end

            S_WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    if (mem_read_q) begin
                        if (grant_q == GNT_I) i_rdata_d = MEM_RDATA;
                        else                  d_rdata_d = MEM_RDATA;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th busy cycle: abandon the access
                    // and hand the requester zero data.
                    err_d = 1'b1;
                    if (mem_read_q) begin
                        if (grant_q == GNT_I) i_rdata_d = '0;
                        else                  d_rdata_d = '0;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            // NOTE: the read-data registers are ordinary flops, not a memory
            // array, so they are reset here like the rest of the state.
            state_q     <= S_IDLE;
            grant_q     <= GNT_D;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    // A port stalls whenever it requests, except in the DONE cycle of its own
    // grant. A port that withdrew its request is therefore never stalled.
    assign I_BUSYWAIT = i_req & ~(state_q == S_DONE && grant_q == GNT_I);
    assign D_BUSYWAIT = d_req & ~(state_q == S_DONE && grant_q == GNT_D);

    assign MEM_READ  = mem_read_q;
    assign MEM_WRITE = mem_write_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign I_RDATA   = i_rdata_q;
    assign D_RDATA   = d_rdata_q;
    assign ERR       = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 8, word address width.
- DATA_W, default 32, data width.
- TIMEOUT, default 64, maximum WAIT-state cycles.
REQ-002 Ports SHALL be as listed below. The single clock is CLK. RESET is asynchronous and active-low.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IREAD  in  1  instruction-fetch read request (level).
- IADDR  in  ADDR_W  instruction-fetch address.
- I_BUSYWAIT  out  1  instruction-port stall.
- I_RDATA  out  DATA_W  instruction-port read data.
- DREAD  in  1  data-port read request (level).
- DWRITE  in  1  data-port write request (level).
- DADDR  in  ADDR_W  data-port address.
- DWDATA  in  DATA_W  data-port write data.
- D_BUSYWAIT  out  1  data-port stall.
- D_RDATA  out  DATA_W  data-port read data.
- MEM_READ  out  1  shared-memory read strobe.
- MEM_WRITE  out  1  shared-memory write strobe.
- MEM_ADDR  out  ADDR_W  shared-memory address.
- MEM_WDATA  out  DATA_W  shared-memory write data.
- MEM_RDATA  in  DATA_W  shared-memory read data.
- MEM_BUSYWAIT  in  1  memory busy; high while an access is in progress.
- ERR  out  1  sticky timeout flag.

Function
REQ-003 The block SHALL share one memory port between the instruction port (I) and the data port (D) using an FSM with four states: IDLE, ISSUE, WAIT, DONE.
REQ-004 A port's request SHALL be I_REQ=IREAD for I and D_REQ=DREAD|DWRITE for D.
REQ-005 Requests SHALL be sampled only in IDLE. At an edge in IDLE with any request pending, the FSM SHALL move to ISSUE, record the granted port, and latch the address (plus DWDATA and the read/write type for D).
REQ-006 When only one port requests, that port SHALL be granted.
REQ-007 When both ports request, the port not granted last SHALL win. The last-grant register SHALL reset to D, so I wins the first tie after reset.
REQ-008 If DREAD and DWRITE are both high, the access SHALL be treated as a write.
REQ-009 From entry to ISSUE until exit from WAIT, MEM_READ or MEM_WRITE (per access type), MEM_ADDR and MEM_WDATA SHALL be driven from the latched values. All are registered outputs.
REQ-010 ISSUE SHALL last exactly one cycle and SHALL ignore MEM_BUSYWAIT; the next edge moves to WAIT.
REQ-011 In WAIT, an edge with MEM_BUSYWAIT=0 SHALL do all of the following:
- capture MEM_RDATA into the granted port's RDATA register (reads only),
- clear MEM_READ and MEM_WRITE,
- move to DONE.
REQ-012 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-013 If the wait counter reaches TIMEOUT with MEM_BUSYWAIT still 1, the FSM SHALL:
- set ERR,
- write 0 to the granted port's RDATA (reads only),
- clear the strobes,
- move to DONE.
REQ-014 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-015 The busywait outputs SHALL be combinational:
- I_BUSYWAIT = I_REQ AND NOT (state==DONE AND grant==I).
- D_BUSYWAIT = D_REQ AND NOT (state==DONE AND grant==D).
REQ-016 The minimum latency for a zero-wait memory SHALL be: request seen at edge 1 (IDLE->ISSUE), edge 2 ISSUE->WAIT, edge 3 WAIT->DONE, with busywait low between edges 3 and 4, and IDLE after edge 4.
REQ-017 RDATA registers SHALL hold their value until the next completed read on the same port. A write SHALL NOT alter D_RDATA.
REQ-018 If a request is withdrawn mid-transaction, the transaction SHALL still complete and RDATA SHALL still update. No busywait SHALL be asserted for the withdrawn port.
REQ-019 A request held through DONE SHALL be treated as a new request at the following IDLE edge.
REQ-020 ERR SHALL stay set until reset; normal operation SHALL continue after ERR is set.

Reset
REQ-021 While RESET=0, asynchronously and independently of CLK, the block SHALL set:
- state=IDLE,
- last-grant=D,
- wait counter=0,
- MEM_READ=MEM_WRITE=0,
- MEM_ADDR=0, MEM_WDATA=0,
- I_RDATA=D_RDATA=0,
- ERR=0.
REQ-022 A reset asserted mid-transaction SHALL drop the strobes immediately and abandon the transaction; the RDATA registers SHALL read 0.
REQ-023 During reset, the busywait outputs SHALL follow their requests.

Verification
REQ-024 Single I read: memory with 0 wait cycles, IREAD=1, IADDR=0x04, MEM_RDATA=0x02060402 -> MEM_READ high for 2 cycles, I_BUSYWAIT low in the 3rd cycle after the request, I_RDATA=0x02060402.
REQ-025 Tie: IREAD and DREAD asserted on the same edge right after reset, DADDR=0x10 -> I served first, then D. Two back-to-back ties alternate I, D, I, D.
REQ-026 D write: DWRITE=1, DADDR=0x20, DWDATA=0xA5A5A5A5, memory busy 3 cycles -> MEM_WRITE high for 5 cycles, MEM_WDATA=0xA5A5A5A5, D_RDATA unchanged, D_BUSYWAIT low exactly one cycle.
REQ-027 Timeout: MEM_BUSYWAIT stuck at 1 on an I read, TIMEOUT=64 -> after 64 WAIT cycles ERR=1, I_RDATA=0, FSM back in IDLE, and a following D read completes normally with ERR still 1.
REQ-028 Reset mid-WAIT: RESET pulled to 0 two cycles into WAIT -> MEM_READ drops without waiting for CLK, all outputs at reset values, and the first request after release is granted normally.
